// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select encodings and the multi-cycle execute FSM state enum.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_stall_fsm.sv
// Holds Execute for MUL_LAT cycles while a multi-cycle op occupies it.
// Stall is raised for the first MUL_LAT-1 cycles; the op leaves on the last.
module mul_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic MultiE,
  output logic MulStall,
  output logic MulBusy
);

  localparam int             CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit             MULTI    = (MUL_LAT > 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MulStall = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        MulStall = MultiE & MULTI;
        if (MultiE && MULTI) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        // cnt==0 is the final Execute cycle: release the stall and let the op go.
        MulStall = MultiE & (cnt_q != '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = MUL_IDLE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign MulBusy = (state_q == MUL_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding,
// load-use and multi-cycle stalls, PC-write tracking and flush generation.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int REGW    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] RA1D,
  input  logic [REGW-1:0] RA2D,
  input  logic            UsesA1D,
  input  logic            UsesA2D,
  input  logic [REGW-1:0] RA1E,
  input  logic [REGW-1:0] RA2E,
  input  logic [REGW-1:0] WA3E,
  input  logic [REGW-1:0] WA3M,
  input  logic [REGW-1:0] WA3W,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            MultiE,
  input  logic            PCWrD,
  input  logic            BranchTakenE,
  input  logic            PCSrcW,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            BubbleM,
  output logic            PCWrPendingF,
  output logic            MulBusy
);

  localparam logic [REGW-1:0] PC_REG = REGW'(NREG - 1);

  logic [REGW-1:0] ra_e  [2];
  logic [1:0]      fwd_e [2];

  assign ra_e[0] = RA1E;
  assign ra_e[1] = RA2E;

  // The PC is never forwarded; its value comes from the fetch path.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_e[gi] = FWD_RF;
        if (RegWriteM && (WA3M == ra_e[gi]) && (ra_e[gi] != PC_REG)) begin
          fwd_e[gi] = FWD_M;
        end else if (RegWriteW && (WA3W == ra_e[gi]) && (ra_e[gi] != PC_REG)) begin
          fwd_e[gi] = FWD_W;
        end
      end
    end
  endgenerate

  assign ForwardAE = fwd_e[0];
  assign ForwardBE = fwd_e[1];

  logic ldr_stall;
  logic mul_stall;

  assign ldr_stall = MemtoRegE & RegWriteE &
                     ((UsesA1D & (RA1D == WA3E)) | (UsesA2D & (RA2D == WA3E)));

  mul_stall_fsm #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_fsm (
    .clk      (clk),
    .reset    (reset),
    .MultiE   (MultiE),
    .MulStall (mul_stall),
    .MulBusy  (MulBusy)
  );

  logic pcw_e_q, pcw_e_d;
  logic pcw_m_q, pcw_m_d;

  // A stalled E emits a bubble into M, so the M copy clears instead of advancing.
  always_comb begin
    pcw_e_d = FlushE ? 1'b0 : (StallE ? pcw_e_q : PCWrD);
    pcw_m_d = StallE ? 1'b0 : pcw_e_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcw_e_q <= 1'b0;
      pcw_m_q <= 1'b0;
    end else begin
      pcw_e_q <= pcw_e_d;
      pcw_m_q <= pcw_m_d;
    end
  end

  assign PCWrPendingF = PCWrD | pcw_e_q | pcw_m_q;

  assign StallF  = ldr_stall | PCWrPendingF | mul_stall;
  assign StallD  = ldr_stall | mul_stall;
  assign StallE  = mul_stall;
  assign BubbleM = mul_stall;
  assign FlushD  = PCWrPendingF | PCSrcW | BranchTakenE;
  assign FlushE  = (ldr_stall | BranchTakenE) & ~mul_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected output
// words; a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       UsesA1D, UsesA2D, RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MultiE, PCWrD, BranchTakenE, PCSrcW;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic       sf0, sd0, se0, fd0, fe0, bm0, pp0, mb0;
  logic       sf1, sd1, se1, fd1, fe1, bm1, pp1, mb1;

  always #5 clk = ~clk;

  hazard_ctrl #(.NREG(16), .REGW(4), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UsesA1D(UsesA1D), .UsesA2D(UsesA2D),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiE(MultiE), .PCWrD(PCWrD), .BranchTakenE(BranchTakenE),
    .PCSrcW(PCSrcW), .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0),
    .StallE(se0), .FlushD(fd0), .FlushE(fe0), .BubbleM(bm0), .PCWrPendingF(pp0), .MulBusy(mb0)
  );

  hazard_ctrl #(.NREG(16), .REGW(4), .MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UsesA1D(UsesA1D), .UsesA2D(UsesA2D),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiE(MultiE), .PCWrD(PCWrD), .BranchTakenE(BranchTakenE),
    .PCSrcW(PCSrcW), .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1),
    .StallE(se1), .FlushD(fd1), .FlushE(fe1), .BubbleM(bm1), .PCWrPendingF(pp1), .MulBusy(mb1)
  );

  // Word layout: {FA[1:0], FB[1:0], StallF, StallD, StallE, FlushD, FlushE, BubbleM, PCWrPendingF, MulBusy}
  logic [11:0] vec0, vec1;
  assign vec0 = {fa0, fb0, sf0, sd0, se0, fd0, fe0, bm0, pp0, mb0};
  assign vec1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, bm1, pp1, mb1};

  typedef struct {
    string       name;
    int          which;
    logic [11:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      logic [11:0] act;
      cur = q.pop_front();
      act = (cur.which == 1) ? vec1 : vec0;
      checks++;
      if (act !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%b expected=%b", cur.name, cur.which, act, cur.exp);
      end else begin
        $display("ok   %s dut%0d out=%b", cur.name, cur.which, act);
      end
    end
  end

  task automatic expect_out(input string n, input int which, input logic [11:0] e);
    exp_t t;
    t.name  = n;
    t.which = which;
    t.exp   = e;
    q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    UsesA1D = 0; UsesA2D = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MultiE = 0; PCWrD = 0; BranchTakenE = 0; PCSrcW = 0;
  endtask

  localparam logic [11:0] ZERO    = 12'b00_00_00000000;
  localparam logic [11:0] LDR     = 12'b00_00_11001000;
  localparam logic [11:0] MUL_S1  = 12'b00_00_11100100;
  localparam logic [11:0] MUL_S2  = 12'b00_00_11100101;
  localparam logic [11:0] MUL_END = 12'b00_00_00000001;
  localparam logic [11:0] PCW     = 12'b00_00_10010010;
  localparam logic [11:0] BR      = 12'b00_00_00011000;
  localparam logic [11:0] BR_MUL  = 12'b00_00_11110100;

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    reset = 1'b0;
    tick();
    expect_out("reset_zero", 0, ZERO);
    expect_out("reset_zero", 1, ZERO);
    tick();
    reset = 1'b1;
    tick();

    // Forwarding: M beats W, W used when M misses, PC never forwarded.
    RegWriteM = 1; WA3M = 5; RA1E = 5; RegWriteW = 1; WA3W = 5; RA2E = 9;
    expect_out("fwd_m_over_w", 0, 12'b10_00_00000000);
    tick();
    RA2E = 7; WA3W = 7;
    expect_out("fwd_a_m_b_w", 0, 12'b10_01_00000000);
    tick();
    RegWriteM = 0; RA1E = 7;
    expect_out("fwd_w_only", 0, 12'b01_01_00000000);
    tick();
    RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 15;
    expect_out("fwd_pc_blocked", 0, ZERO);
    tick();
    clr_inputs();

    // Load-use
    MemtoRegE = 1; RegWriteE = 1; WA3E = 3; RA2D = 3; UsesA2D = 1;
    expect_out("ldr_use_b", 0, LDR);
    tick();
    UsesA2D = 0;
    expect_out("ldr_unused_b", 0, ZERO);
    tick();
    RA1D = 3; UsesA1D = 1;
    expect_out("ldr_use_a", 0, LDR);
    tick();
    RegWriteE = 0;
    expect_out("ldr_nowrite", 0, ZERO);
    tick();
    clr_inputs();

    // Multi-cycle op, MUL_LAT=3 and MUL_LAT=1
    MultiE = 1;
    expect_out("mul_c1", 0, MUL_S1);
    expect_out("mul1_c1", 1, ZERO);
    tick();
    expect_out("mul_c2", 0, MUL_S2);
    expect_out("mul1_c2", 1, ZERO);
    tick();
    expect_out("mul_c3", 0, MUL_END);
    expect_out("mul1_c3", 1, ZERO);
    tick();
    MultiE = 0;
    expect_out("mul_idle", 0, ZERO);
    tick();

    // PC write pending for 3 cycles
    PCWrD = 1;
    expect_out("pcw_c0", 0, PCW);
    tick();
    PCWrD = 0;
    expect_out("pcw_c1", 0, PCW);
    tick();
    expect_out("pcw_c2", 0, PCW);
    tick();
    expect_out("pcw_done", 0, ZERO);
    tick();

    // Branch alone flushes E; with MulStall E is held instead
    BranchTakenE = 1;
    expect_out("branch_alone", 0, BR);
    tick();
    MultiE = 1;
    expect_out("branch_vs_mul", 0, BR_MUL);
    tick();
    BranchTakenE = 0;
    expect_out("br_mul_c2", 0, MUL_S2);
    tick();
    expect_out("br_mul_c3", 0, MUL_END);
    tick();
    MultiE = 0;
    tick();

    // Reset mid-BUSY with cnt=1, then repeat the full sequence
    MultiE = 1;
    expect_out("rst_pre_c1", 0, MUL_S1);
    tick();
    reset = 0; MultiE = 0;
    expect_out("rst_mid_busy", 0, ZERO);
    tick();
    expect_out("rst_held", 0, ZERO);
    tick();
    reset = 1; MultiE = 1;
    expect_out("rerun_c1", 0, MUL_S1);
    tick();
    expect_out("rerun_c2", 0, MUL_S2);
    tick();
    expect_out("rerun_c3", 0, MUL_END);
    tick();
    MultiE = 0;
    expect_out("rerun_idle", 0, ZERO);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage ARM core (F/D/E/M/W). It supersedes the purely combinational hazard logic. It adds register-width and register-count generalisation, explicit operand-use qualifiers, and internally tracked PC-write-pending state. It also supports a multi-cycle execute op (multiply) that holds Execute for `MUL_LAT` cycles. The block sits beside the datapath and drives all forward-select, stall and flush controls.

## Interface
- `NREG`, 16, architectural register count; register `NREG-1` is the PC and is never forwarded.
- `REGW`, 4, register-address width, `$clog2(NREG)`.
- `MUL_LAT`, 3, Execute occupancy of a multi-cycle op in cycles, ≥1.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `RA1D`, `RA2D` in REGW: Decode source registers. `UsesA1D`, `UsesA2D` in 1: those sources are actually read.
- `RA1E`, `RA2E` in REGW: Execute source registers.
- `WA3E`, `WA3M`, `WA3W` in REGW: destination register per stage. `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: matching write enables.
- `MemtoRegE` in 1: the instruction in E is a load.
- `MultiE` in 1: the instruction in E is a multi-cycle op.
- `PCWrD` in 1: the instruction in D writes the PC.
- `BranchTakenE`, `PCSrcW` in 1: branch resolved taken in E; PC write retiring in W.
- `ForwardAE`, `ForwardBE` out 2: operand source select, 00 = register file, 01 = W result, 10 = M ALU result.
- `StallF`, `StallD`, `StallE` out 1: hold the F/D/E pipeline registers.
- `FlushD`, `FlushE` out 1: clear the D/E pipeline registers.
- `BubbleM` out 1: insert a bubble into M.
- `PCWrPendingF` out 1: a PC write is in flight in D, E or M.
- `MulBusy` out 1: the multi-cycle FSM is in BUSY.

## Operation
- **Forwarding (per operand A/B, combinational):**
  - 10 if `RegWriteM` and `WA3M==RAxE` and `RAxE!=NREG-1`.
  - Otherwise 01 if the same condition holds for W.
  - Otherwise 00.
  - M has priority over W.
- **Load-use stall:** `LdrStall = MemtoRegE & RegWriteE & ((UsesA1D & RA1D==WA3E) | (UsesA2D & RA2D==WA3E))`.
- **PC-write tracking:** two flops, `pcwE` and `pcwM`.
  - `pcwE <= FlushE ? 0 : StallE ? pcwE : PCWrD`.
  - `pcwM <= StallE ? 0 : pcwE`.
  - `PCWrPendingF = PCWrD | pcwE | pcwM`.
- **Multi-cycle FSM, states IDLE and BUSY, counter `cnt` of width `$clog2(MUL_LAT)`:**
  - `MulStall = MultiE & (MUL_LAT>1) & (IDLE | cnt!=0)`.
  - IDLE, with `MultiE` and `MUL_LAT>1`: go to BUSY and load `cnt <= MUL_LAT-2`.
  - BUSY, with `cnt!=0`: `cnt--`.
  - BUSY, with `cnt==0`: go to IDLE; the op leaves E this cycle.
  - When `MUL_LAT==1`, the FSM never leaves IDLE.
- **Outputs:**
  - `StallF = LdrStall | PCWrPendingF | MulStall`.
  - `StallD = LdrStall | MulStall`.
  - `StallE = MulStall`.
  - `BubbleM = MulStall`.
  - `FlushD = PCWrPendingF | PCSrcW | BranchTakenE`.
  - `FlushE = (LdrStall | BranchTakenE) & ~MulStall`.
- **Simultaneous events:**
  - `MulStall` dominates any flush of E: E is held and never flushed while stalled.
  - `FlushD` overrides `StallD`.

## Timing
- All forward, stall and flush outputs are combinational from the current inputs and state; zero latency.
- A multi-cycle op occupies E for exactly `MUL_LAT` cycles. `MulStall` is high for the first `MUL_LAT-1` of them.
- `PCWrPendingF` stays high for 3 consecutive cycles after a PC-writing instruction enters D, provided there is no stall or flush.
- **Reset:** asserting `reset` low at any time, including mid-BUSY, immediately forces IDLE, `cnt=0`, `pcwE=0` and `pcwM=0`.
- **Outputs under reset with inputs zero:** all outputs are 0; forward selects are 00.

## Structure
- Package `hazard_pkg` holds:
  - the forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`;
  - the FSM state enum `{MUL_IDLE, MUL_BUSY}`.
- Sub-module `mul_stall_fsm` (params `MUL_LAT`; ports `clk`, `reset`, `MultiE`, `MulStall`, `MulBusy`) contains the counter and FSM.
- The top level contains the comparators, the PC-write tracker and the output logic.

## Test plan
- `RegWriteM=1`, `WA3M=5`, `RA1E=5`, and W also matching → `ForwardAE=10`. With `RA1E=15`, W matching → `ForwardAE=00`.
- Load in E with `WA3E=3`, D reads `RA2D=3` with `UsesA2D=1` → `StallF=StallD=FlushE=1` for one cycle. With `UsesA2D=0` → no stall.
- `MUL_LAT=3`, `MultiE` held until the op leaves:
  - `StallE`/`BubbleM` read 1, 1, 0 over 3 cycles.
  - `MulBusy` reads 0, 1, 1.
  - The FSM returns to IDLE.
  - A repeat with `MUL_LAT=1` never stalls.
- `PCWrD` pulsed for 1 cycle → `PCWrPendingF` high for 3 cycles; `FlushD` high throughout.
- `BranchTakenE` coincident with `MulStall` → `FlushE=0` and `StallE=1`.
- `reset` dropped low while `cnt=1` in BUSY → next state IDLE and all outputs 0. Release, then re-issue `MultiE` → the full 3-cycle sequence repeats.
